// File: rtl/mux10_16_bit.sv
// rtl/mux10_16_bit.sv - ten-source 16-bit registered bus multiplexer

// 16-bit 2:1 mux: y = sel ? b : a
module mux10_16_bit_mux2 (
    input  logic        sel,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] y
);
    assign y = sel ? b : a;
endmodule

module mux10_16_bit (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] r0,
    input  logic [15:0] r1,
    input  logic [15:0] r2,
    input  logic [15:0] r3,
    input  logic [15:0] r4,
    input  logic [15:0] r5,
    input  logic [15:0] r6,
    input  logic [15:0] r7,
    input  logic [15:0] din,
    input  logic [15:0] aluout,
    input  logic [2:0]  rout,
    input  logic        din_en,
    input  logic        gout,
    output logic [15:0] buswires
);
    // First tree level: pairs selected by rout[0]
    logic [15:0] lvl1_0;
    logic [15:0] lvl1_1;
    logic [15:0] lvl1_2;
    logic [15:0] lvl1_3;
    // Second tree level: selected by rout[1]
    logic [15:0] lvl2_0;
    logic [15:0] lvl2_1;
    // Tree root, ALU override, then din override
    logic [15:0] reg_sel;
    logic [15:0] alu_sel;
    logic [15:0] bus_next;

    mux10_16_bit_mux2 u_l1_0 (.sel(rout[0]), .a(r0), .b(r1), .y(lvl1_0));
    mux10_16_bit_mux2 u_l1_1 (.sel(rout[0]), .a(r2), .b(r3), .y(lvl1_1));
    mux10_16_bit_mux2 u_l1_2 (.sel(rout[0]), .a(r4), .b(r5), .y(lvl1_2));
    mux10_16_bit_mux2 u_l1_3 (.sel(rout[0]), .a(r6), .b(r7), .y(lvl1_3));

    mux10_16_bit_mux2 u_l2_0 (.sel(rout[1]), .a(lvl1_0), .b(lvl1_1), .y(lvl2_0));
    mux10_16_bit_mux2 u_l2_1 (.sel(rout[1]), .a(lvl1_2), .b(lvl1_3), .y(lvl2_1));

    mux10_16_bit_mux2 u_l3   (.sel(rout[2]), .a(lvl2_0), .b(lvl2_1), .y(reg_sel));

    // gout sits below din_en so din always wins when both are set
    mux10_16_bit_mux2 u_alu  (.sel(gout),    .a(reg_sel), .b(aluout), .y(alu_sel));
    mux10_16_bit_mux2 u_din  (.sel(din_en),  .a(alu_sel), .b(din),    .y(bus_next));

    // Bus register with synchronous clear; no combinational path to the output
    always_ff @(posedge clk) begin
        if (rst) begin
            buswires <= 16'h0000;
        end else begin
            buswires <= bus_next;
        end
    end
endmodule

// File: tb/tb_mux10_16_bit.sv
// tb/tb_mux10_16_bit.sv - self-checking bench for mux10_16_bit
`timescale 1ns/1ps

module tb_mux10_16_bit;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] r [8];
    logic [15:0] din;
    logic [15:0] aluout;
    logic [2:0]  rout;
    logic        din_en;
    logic        gout;
    logic [15:0] buswires;

    int total = 0;
    int bad   = 0;

    logic [15:0] exp_bus;
    logic        exp_valid = 1'b0;

    mux10_16_bit dut (
        .clk(clk), .rst(rst),
        .r0(r[0]), .r1(r[1]), .r2(r[2]), .r3(r[3]),
        .r4(r[4]), .r5(r[5]), .r6(r[6]), .r7(r[7]),
        .din(din), .aluout(aluout), .rout(rout),
        .din_en(din_en), .gout(gout), .buswires(buswires)
    );

    always #5 clk = ~clk;

    // Reference: priority rule applied to the values present at each rising edge
    always @(posedge clk) begin
        if (rst)         exp_bus <= 16'h0000;
        else if (din_en) exp_bus <= din;
        else if (gout)   exp_bus <= aluout;
        else             exp_bus <= r[rout];
        exp_valid <= 1'b1;
    end

    // Continuous compare against the reference, away from the active edge
    always @(negedge clk) begin
        if (exp_valid) begin
            total++;
            if (buswires !== exp_bus) begin
                bad++;
                $display("FAIL model t=%0t got=%h exp=%h", $time, buswires, exp_bus);
            end
        end
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, act, req);
        end
    endtask

    // Advance one rising edge, then settle just after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; din = 16'h0; aluout = 16'h0; rout = 3'd0; din_en = 1'b0; gout = 1'b0;
        for (int i = 0; i < 8; i++) r[i] = 16'h0;
        r[0] = 16'hFFFF;

        // 1. reset
        step(); check("reset_e1", buswires, 16'h0000);
        step(); check("reset_e2", buswires, 16'h0000);
        rst = 1'b0;
        step(); check("reset_release", buswires, 16'hFFFF);

        // 2. register sweep
        for (int i = 0; i < 8; i++) r[i] = 16'h1000 + 16'(i);
        for (int i = 0; i < 8; i++) begin
            rout = 3'(i);
            step();
            check($sformatf("sweep_r%0d", i), buswires, 16'h1000 + 16'(i));
        end

        // 3. ALU select
        r[2] = 16'h1234; rout = 3'd2; gout = 1'b1; aluout = 16'hA5A5;
        step(); check("alu_sel", buswires, 16'hA5A5);
        gout = 1'b0;
        step(); check("alu_drop", buswires, 16'h1234);

        // 4. priority
        din_en = 1'b1; gout = 1'b1; din = 16'h00FF; aluout = 16'hFF00;
        step(); check("prio_din", buswires, 16'h00FF);
        din_en = 1'b0;
        step(); check("prio_alu", buswires, 16'hFF00);
        gout = 1'b0;

        // 5. registered behaviour
        r[4] = 16'h0001; rout = 3'd4;
        step(); check("reg_before", buswires, 16'h0001);
        #2 r[4] = 16'h8000;
        #2 check("reg_hold", buswires, 16'h0001);
        step(); check("reg_after", buswires, 16'h8000);

        // 6. randomised, with a one-edge reset pulse mid-run
        for (int c = 0; c < 500; c++) begin
            for (int i = 0; i < 8; i++) r[i] = 16'($urandom);
            din    = 16'($urandom);
            aluout = 16'($urandom);
            rout   = 3'($urandom_range(0, 7));
            din_en = ($urandom_range(0, 3) == 0);
            gout   = ($urandom_range(0, 2) == 0);
            rst    = (c == 250);
            step();
            if (c == 250) check("rand_rst", buswires, 16'h0000);
        end
        rst = 1'b0;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
